// File: rtl/meter_counter.sv
// Parking-meter countdown: 4-digit packed BCD seconds with add/load requests.
// Define METER_BUTTON_EDGE_EN to accept add_*/load_* only on 0->1 transitions.
module meter_counter #(
    parameter logic [15:0] MAX_BCD    = 16'h9999,
    parameter logic [15:0] LOAD_A_BCD = 16'h0010,
    parameter logic [15:0] LOAD_B_BCD = 16'h0205
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1Hz,
    input  logic        add_60,
    input  logic        add_120,
    input  logic        add_180,
    input  logic        add_300,
    input  logic        load_a,
    input  logic        load_b,
    output logic [15:0] BCD_out,
    output logic        expired
);

    typedef enum logic {
        S_EXPIRED = 1'b0,
        S_RUNNING = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_bcd;
    logic        r_expired;
    logic [15:0] w_bcd_nxt;
    logic [15:0] w_dec;
    logic [15:0] w_amt;
    logic [16:0] w_sum;
    logic [5:0]  w_req;
    logic        w_a60;
    logic        w_a120;
    logic        w_a180;
    logic        w_a300;
    logic        w_la;
    logic        w_lb;

    assign w_req = {load_b, load_a, add_300, add_180, add_120, add_60};

`ifdef METER_BUTTON_EDGE_EN
    logic [5:0] r_req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q <= 6'b0;
        end else begin
            r_req_q <= w_req;
        end
    end

    assign {w_lb, w_la, w_a300, w_a180, w_a120, w_a60} = w_req & ~r_req_q;
`else
    assign {w_lb, w_la, w_a300, w_a180, w_a120, w_a60} = w_req;
`endif

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  d;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d      = 4'd9;
                    borrow = 1'b1;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    // Digit-serial decimal add; bit 16 is the carry out of the top digit.
    function automatic logic [16:0] bcd_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [15:0] r;
        logic [4:0]  s;
        logic        c;
        r = 16'h0000;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        return {c, r};
    endfunction

    always_comb begin
        w_dec = r_bcd;
        if (tick_1Hz && (r_state == S_RUNNING)) begin
            w_dec = bcd_dec(r_bcd);
        end

        w_amt = 16'h0000;
        if (w_a300) begin
            w_amt = 16'h0300;
        end else if (w_a180) begin
            w_amt = 16'h0180;
        end else if (w_a120) begin
            w_amt = 16'h0120;
        end else if (w_a60) begin
            w_amt = 16'h0060;
        end

        w_sum = bcd_add(w_dec, w_amt);
        if (w_sum[16] || (w_sum[15:0] > MAX_BCD)) begin
            w_bcd_nxt = MAX_BCD;
        end else begin
            w_bcd_nxt = w_sum[15:0];
        end

        if (w_lb) begin
            w_bcd_nxt = LOAD_B_BCD;
        end else if (w_la) begin
            w_bcd_nxt = LOAD_A_BCD;
        end

        w_state_nxt = (w_bcd_nxt == 16'h0000) ? S_EXPIRED : S_RUNNING;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_EXPIRED;
            r_bcd     <= 16'h0000;
            r_expired <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_bcd     <= w_bcd_nxt;
            r_expired <= (w_state_nxt == S_EXPIRED);
        end
    end

    assign BCD_out = r_bcd;
    assign expired = r_expired;

endmodule

// File: tb/tb_meter_counter.sv
// Scoreboard bench for meter_counter; a decimal-integer model predicts each cycle.
// Honours METER_BUTTON_EDGE_EN when defined for the build.
module tb_meter_counter;

    logic        clk;
    logic        rst;
    logic        tick_1Hz;
    logic        add_60;
    logic        add_120;
    logic        add_180;
    logic        add_300;
    logic        load_a;
    logic        load_b;
    logic [15:0] BCD_out;
    logic        expired;

    int          n_cmp;
    int          n_bad;
    int          m_sec;
    logic [5:0]  m_prev;
    logic [16:0] sb_q[$];

    meter_counter dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1Hz (tick_1Hz),
        .add_60   (add_60),
        .add_120  (add_120),
        .add_180  (add_180),
        .add_300  (add_300),
        .load_a   (load_a),
        .load_b   (load_b),
        .BCD_out  (BCD_out),
        .expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] got,
                         input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got exp=%b bcd=%h, want exp=%b bcd=%h",
                     tag, got[16], got[15:0], exp[16], exp[15:0]);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // ad = {add_300, add_180, add_120, add_60}
    task automatic step(input logic t, input logic [3:0] ad,
                        input logic la, input logic lb, input logic r);
        logic [5:0]  cur;
        logic [5:0]  acc;
        logic [16:0] got;
        logic [15:0] eb;
        @(negedge clk);
        rst      = r;
        tick_1Hz = t;
        {add_300, add_180, add_120, add_60} = ad;
        load_a   = la;
        load_b   = lb;
        cur = {lb, la, ad};
`ifdef METER_BUTTON_EDGE_EN
        acc = cur & ~m_prev;
`else
        acc = cur;
`endif
        m_prev = r ? 6'b0 : cur;
        if (r) begin
            m_sec = 0;
        end else if (acc[5]) begin
            m_sec = 205;
        end else if (acc[4]) begin
            m_sec = 10;
        end else begin
            if (t && m_sec > 0) m_sec = m_sec - 1;
            if (acc[3]) m_sec = m_sec + 300;
            else if (acc[2]) m_sec = m_sec + 180;
            else if (acc[1]) m_sec = m_sec + 120;
            else if (acc[0]) m_sec = m_sec + 60;
            if (m_sec > 9999) m_sec = 9999;
        end
        eb = to_bcd(m_sec);
        sb_q.push_back({(m_sec == 0), eb});
        @(posedge clk);
        #1;
        got = {expired, BCD_out};
        if (sb_q.size() == 0) check("sb_empty", got, 17'h1ffff);
        else check("sb", got, sb_q.pop_front());
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add(input logic [3:0] ad);
        step(1'b0, ad, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic do_rst();
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic lit(input string tag, input logic e, input logic [15:0] b);
        check(tag, {expired, BCD_out}, {e, b});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_sec = 0;
        m_prev = 6'b0;
        {rst, tick_1Hz, add_60, add_120, add_180, add_300, load_a, load_b} = '0;

        do_rst();
        do_rst();
        lit("reset", 1'b1, 16'h0000);
        idle();
        tick_n(1);
        lit("tick_at_zero", 1'b1, 16'h0000);

        step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        lit("load_b", 1'b0, 16'h0205);
        tick_n(6);
        lit("borrow_0199", 1'b0, 16'h0199);

        do_rst();
        add(4'b0010);
        tick_n(20);
        lit("at_0100", 1'b0, 16'h0100);
        tick_n(1);
        lit("borrow_0099", 1'b0, 16'h0099);

        do_rst();
        for (int i = 0; i < 33; i++) add(4'b1000);
        lit("at_9900", 1'b0, 16'h9900);
        add(4'b1000);
        lit("saturate", 1'b0, 16'h9999);
        step(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        lit("sat_tick_add", 1'b0, 16'h9999);

        do_rst();
        step(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);
        lit("add_largest", 1'b0, 16'h0300);
        idle();
        step(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
        lit("add_180_wins", 1'b0, 16'h0480);

        step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick_n(9);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        lit("tick_add_0001", 1'b0, 16'h0060);
        step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick_n(9);
        lit("at_0001", 1'b0, 16'h0001);
        tick_n(1);
        lit("expire", 1'b1, 16'h0000);

        add(4'b1000);
        add(4'b0010);
        add(4'b0001);
        add(4'b0001);
        tick_n(40);
        lit("at_0500", 1'b0, 16'h0500);
        step(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        lit("load_a_wins", 1'b0, 16'h0010);
        idle();
        step(1'b1, 4'b1000, 1'b1, 1'b1, 1'b0);
        lit("load_b_wins", 1'b0, 16'h0205);

        do_rst();
        add(4'b1000);
        add(4'b1000);
        add(4'b0010);
        add(4'b0001);
        tick_n(30);
        lit("at_0750", 1'b0, 16'h0750);
        step(1'b1, 4'b0010, 1'b1, 1'b1, 1'b1);
        lit("rst_override", 1'b1, 16'h0000);
        step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        lit("post_rst_req", 1'b0, 16'h0060);

        do_rst();
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
`ifdef METER_BUTTON_EDGE_EN
        lit("hold_add60", 1'b0, 16'h0060);
`else
        lit("hold_add60", 1'b0, 16'h0600);
`endif
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/meter_counter.md
METER_COUNTER -- requirements
Module: meter_counter

Interface
REQ-001 Parameter MAX_BCD, default 16'h9999, saturation ceiling of the 4-digit BCD count.
REQ-002 Parameter LOAD_A_BCD, default 16'h0010, value loaded by load_a.
REQ-003 Parameter LOAD_B_BCD, default 16'h0205, value loaded by load_b.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 tick_1Hz  input  1  one-clk-wide enable pulse, once per second.
REQ-007 add_60 / add_120 / add_180 / add_300  input  1 each  add-time requests; add 60/120/180/300 seconds.
REQ-008 load_a / load_b  input  1 each  overwrite the count with LOAD_A_BCD / LOAD_B_BCD.
REQ-009 BCD_out  output  16  remaining seconds, 4 packed BCD digits, [15:12] most significant; feeds the display flasher's BCD_in.
REQ-010 expired  output  1  high exactly when BCD_out == 16'h0000.

Function
REQ-011 The block SHALL be a two-state FSM: EXPIRED (count 0) and RUNNING (count > 0).
REQ-012 EXPIRED -> RUNNING SHALL occur on any accepted add or load that yields a nonzero count.
REQ-013 RUNNING -> EXPIRED SHALL occur on a tick that decrements 0001 to 0000, or on a load of 0000.
REQ-014 All outputs SHALL be registered; the effect of a request sampled at edge N SHALL be visible on BCD_out after edge N.
REQ-015 Priority per cycle SHALL be: rst > load_b > load_a > add/tick.
REQ-016 On an accepted load, a simultaneous tick and all add requests SHALL be ignored that cycle.
REQ-017 Among add requests in the same cycle, only the largest SHALL be applied: add_300 > add_180 > add_120 > add_60.
REQ-018 On tick with count > 0, the count SHALL decrement by 1 in BCD, with digit borrow (e.g. 0100 -> 0099).
REQ-019 On tick with count == 0, the count SHALL remain 0000; no wrap to 9999.
REQ-020 On simultaneous tick and add: decrement first (per REQ-018/019), then add.
REQ-021 Addition SHALL be digit-serial BCD with decimal carry; any digit result > 9 SHALL be corrected by +6.
REQ-022 Any sum exceeding MAX_BCD (including carry out of digit 3) SHALL saturate to MAX_BCD.
REQ-023 Add amounts SHALL be applied as BCD constants 0060, 0120, 0180, 0300.
REQ-024 BCD_out SHALL never hold a non-BCD digit (A-F).
REQ-025 expired SHALL be derived from the next-state count and registered together with BCD_out, so the two never disagree.

Reset
REQ-026 While rst is high at a clock edge: BCD_out = 16'h0000, expired = 1, FSM = EXPIRED, and all edge-detect registers = 0.
REQ-027 rst asserted mid-count SHALL override any same-cycle tick, add or load.
REQ-028 The first request sampled on the edge after rst deasserts SHALL be honoured.

Configuration
REQ-029 Macro METER_BUTTON_EDGE_EN SHALL select the input handling for add_* and load_*.
REQ-030 With METER_BUTTON_EDGE_EN defined, add_* and load_* SHALL be treated as levels.
  - Each is registered internally.
  - A request is accepted only on a 0->1 transition, once per press.
  - Holding a level high for N cycles SHALL count once.
REQ-031 Without the macro, add_* and load_* SHALL be taken as one-clk pulses and accepted on every cycle they are high.
  - No edge registers are instantiated.

Verification
REQ-032 rst=1 for 2 clks, then idle -> BCD_out=0000, expired=1; tick with count 0 -> stays 0000.
REQ-033 load_b, then 6 ticks -> 0205 then 0199; a tick at 0100 -> 0099.
REQ-034 Count 9900 + add_300 -> 9999 (saturated); add_60 and add_300 in the same cycle from 0000 -> 0300.
REQ-035 Count 0001 with tick and add_60 in the same cycle -> 0060, expired stays 0; count 0001 with tick only -> 0000, expired=1.
REQ-036 load_a with tick and add_180 in the same cycle from 0500 -> 0010; rst asserted at count 0750 with add_120 -> 0000.
REQ-037 With METER_BUTTON_EDGE_EN: add_60 held 10 clks from 0000 -> 0060; without it -> 0600.
